// File: rtl/i2s_dsp_pkg.sv
// Shared types and field widths for the I2S DSP frame-sync path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2s_dsp_pkg;

  // Frame-sync generator states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } ws_state_e;

  // Bits-per-word field (value is bits minus 1)
  localparam int BITS_W = 5;
  // Words-per-frame field (value is words minus 1)
  localparam int WORDS_W = 4;
  // Longest frame in sck cycles: 16 words of 32 bits
  localparam int MAX_FRAME_LEN = (1 << WORDS_W) * (1 << BITS_W);

endpackage

// File: rtl/i2s_dsp_frame_cnt.sv
// Bit/word counter pair for one DSP frame, with wrap and frame terminal count.
// Latency: counters update on the edge after adv/clr; next values are exposed combinationally.
// Backpressure: none; the owner decides each cycle whether to advance, hold or clear.
module i2s_dsp_frame_cnt
  import i2s_dsp_pkg::*;
(
  input  logic               sck_i,
  input  logic               rst_i,
  input  logic               clr,
  input  logic               adv,
  input  logic [BITS_W-1:0]  nb,
  input  logic [WORDS_W-1:0] nw,
  output logic [BITS_W-1:0]  bit_nxt,
  output logic [WORDS_W-1:0] word_nxt,
  output logic               frame_tc
);

  logic [BITS_W-1:0]  bit_q;
  logic [WORDS_W-1:0] word_q;
  logic               bit_tc;

  // Terminal counts against the frame's latched geometry
  always_comb begin
    bit_tc   = (bit_q == nb);
    frame_tc = bit_tc && (word_q == nw);
  end

  // Next counter values: clear wins, then advance with wrap at the word and frame boundary
  always_comb begin
    bit_nxt  = bit_q;
    word_nxt = word_q;
    if (clr) begin
      bit_nxt  = '0;
      word_nxt = '0;
    end else if (adv) begin
      if (bit_tc) begin
        bit_nxt  = '0;
        word_nxt = frame_tc ? '0 : word_q + 4'd1;
      end else begin
        bit_nxt = bit_q + 5'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      bit_q  <= '0;
      word_q <= '0;
    end else begin
      bit_q  <= bit_nxt;
      word_q <= word_nxt;
    end
  end

endmodule

// File: rtl/i2s_dsp_ws_gen.sv
// Master frame-sync / word strobe generator for the DSP TX channel; optional long sync via I2S_DSP_WS_LONG_FS_EN.
// Latency: first ws_o one cycle after cfg_en_i & master_ready_to_send_i are sampled in IDLE; all outputs registered.
// Backpressure: a frame only starts while the channel is ready; a ready drop lets the frame finish, an enable drop aborts at once.
module i2s_dsp_ws_gen
  import i2s_dsp_pkg::*;
#(
  parameter int GAP_W = 8
) (
  input  logic               sck_i,
  input  logic               rst_i,
  input  logic               cfg_en_i,
  input  logic [BITS_W-1:0]  cfg_num_bits_i,
  input  logic [WORDS_W-1:0] cfg_num_word_i,
  input  logic [GAP_W-1:0]   cfg_gap_i,
`ifdef I2S_DSP_WS_LONG_FS_EN
  input  logic               cfg_long_fs_i,
`endif
  input  logic               master_ready_to_send_i,
  output logic               ws_o,
  output logic               word_start_o,
  output logic [WORDS_W-1:0] word_idx_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  ws_state_e          state_q, state_nxt;
  logic [BITS_W-1:0]  nb_q, nb_nxt;
  logic [WORDS_W-1:0] nw_q, nw_nxt;
  logic [GAP_W-1:0]   gap_q, gap_cfg_nxt;
  logic [GAP_W-1:0]   gap_cnt_q, gap_nxt;
  logic               start_ok;
  logic               latch;
  logic               cnt_clr;
  logic               cnt_adv;
  logic [BITS_W-1:0]  bit_nxt;
  logic [WORDS_W-1:0] word_nxt;
  logic               frame_tc;
  logic               in_frame_nxt;
  logic               ws_nxt;
  logic               word_start_nxt;
  logic               frame_done_nxt;

`ifdef I2S_DSP_WS_LONG_FS_EN
  logic               long_q, long_nxt;
`endif

  i2s_dsp_frame_cnt u_frame_cnt (
    .sck_i    (sck_i),
    .rst_i    (rst_i),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .nb       (nb_q),
    .nw       (nw_q),
    .bit_nxt  (bit_nxt),
    .word_nxt (word_nxt),
    .frame_tc (frame_tc)
  );

  assign start_ok = cfg_en_i & master_ready_to_send_i;

  // Next state, counter control and gap counting; disable overrides every state
  always_comb begin
    state_nxt = state_q;
    gap_nxt   = gap_cnt_q;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    latch     = 1'b0;
    if (!cfg_en_i) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
      gap_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_clr = 1'b1;
          gap_nxt = '0;
          if (start_ok) begin
            latch     = 1'b1;
            state_nxt = FRAME;
          end
        end
        FRAME: begin
          cnt_adv = 1'b1;
          if (frame_tc) begin
            gap_nxt = '0;
            if (gap_q != '0) begin
              state_nxt = GAP;
            end else if (start_ok) begin
              latch     = 1'b1;
              state_nxt = FRAME;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == gap_q - GAP_ONE) begin
            gap_nxt = '0;
            if (start_ok) begin
              latch     = 1'b1;
              state_nxt = FRAME;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            gap_nxt = gap_cnt_q + GAP_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
          gap_nxt   = '0;
        end
      endcase
    end
  end

  // Shadow config: only a frame start picks up new settings
  always_comb begin
    nb_nxt      = latch ? cfg_num_bits_i : nb_q;
    nw_nxt      = latch ? cfg_num_word_i : nw_q;
    gap_cfg_nxt = latch ? cfg_gap_i      : gap_q;
  end

`ifdef I2S_DSP_WS_LONG_FS_EN
  // Long-sync flag latched with the rest of the frame config
  always_comb begin
    long_nxt = latch ? cfg_long_fs_i : long_q;
  end
`endif

  // Output decode from the state the next edge will enter, so outputs can be registered
  always_comb begin
    in_frame_nxt   = (state_nxt == FRAME);
    word_start_nxt = in_frame_nxt && (bit_nxt == '0);
    frame_done_nxt = in_frame_nxt && (bit_nxt == nb_nxt) && (word_nxt == nw_nxt);
`ifdef I2S_DSP_WS_LONG_FS_EN
    ws_nxt         = in_frame_nxt && (word_nxt == '0) && ((bit_nxt == '0) || long_nxt);
`else
    ws_nxt         = in_frame_nxt && (word_nxt == '0) && (bit_nxt == '0);
`endif
  end

  // FSM state, shadow config, gap counter and registered outputs
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      nb_q         <= '0;
      nw_q         <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      ws_o         <= 1'b0;
      word_start_o <= 1'b0;
      word_idx_o   <= '0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      nb_q         <= nb_nxt;
      nw_q         <= nw_nxt;
      gap_q        <= gap_cfg_nxt;
      gap_cnt_q    <= gap_nxt;
      ws_o         <= ws_nxt;
      word_start_o <= word_start_nxt;
      word_idx_o   <= word_nxt;
      frame_done_o <= frame_done_nxt;
      busy_o       <= (state_nxt != IDLE);
    end
  end

`ifdef I2S_DSP_WS_LONG_FS_EN
  // Long-sync shadow register
  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      long_q <= 1'b0;
    end else begin
      long_q <= long_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dsp_ws_gen.sv
// Directed scoreboard bench for i2s_dsp_ws_gen.
// Latency: expectations are queued per sck cycle and popped at each falling edge.
// Backpressure: exercises ready and enable drops.
module tb_i2s_dsp_ws_gen;

  localparam int GAP_W = 8;
  localparam logic [7:0] IDLEV = 8'h00;
  localparam logic [7:0] GAPV  = 8'h01;

  logic             sck = 1'b0;
  logic             rst;
  logic             en;
  logic             rdy;
  logic [4:0]       nb;
  logic [3:0]       nw;
  logic [GAP_W-1:0] gap;
`ifdef I2S_DSP_WS_LONG_FS_EN
  logic             long_fs;
`endif
  logic             ws;
  logic             ws_start;
  logic [3:0]       idx;
  logic             done;
  logic             busy;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         lng_exp = 1'b0;
  logic [7:0] exp_q[$];

  always #5 sck = ~sck;

  i2s_dsp_ws_gen #(.GAP_W(GAP_W)) dut (
    .sck_i                  (sck),
    .rst_i                  (rst),
    .cfg_en_i               (en),
    .cfg_num_bits_i         (nb),
    .cfg_num_word_i         (nw),
    .cfg_gap_i              (gap),
`ifdef I2S_DSP_WS_LONG_FS_EN
    .cfg_long_fs_i          (long_fs),
`endif
    .master_ready_to_send_i (rdy),
    .ws_o                   (ws),
    .word_start_o           (ws_start),
    .word_idx_o             (idx),
    .frame_done_o           (done),
    .busy_o                 (busy)
  );

  // Expected {ws, word_start, word_idx[3:0], frame_done, busy} for one frame cycle
  function automatic logic [7:0] frm(input int b, input int w, input int nbv, input int nwv, input bit lng);
    logic [7:0] v;
    v[7]   = (w == 0) && ((b == 0) || lng);
    v[6]   = (b == 0);
    v[5:2] = 4'(w);
    v[1]   = (b == nbv) && (w == nwv);
    v[0]   = 1'b1;
    return v;
  endfunction

  task automatic push_const(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Frame cycles from offset lo to hi inclusive
  task automatic push_range(input int nbv, input int nwv, input bit lng, input int lo, input int hi);
    for (int off = lo; off <= hi; off++)
      exp_q.push_back(frm(off % (nbv + 1), off / (nbv + 1), nbv, nwv, lng));
  endtask

  task automatic push_frame(input int nbv, input int nwv, input bit lng);
    push_range(nbv, nwv, lng, 0, (nbv + 1) * (nwv + 1) - 1);
  endtask

  task automatic run(input int n, input string tag);
    logic [7:0] obs;
    logic [7:0] exp_v;
    for (int i = 0; i < n; i++) begin
      @(negedge sck);
      obs = {ws, ws_start, idx, done, busy};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL %s cyc=%0d observed=%h expected=<nothing queued>", tag, i, obs);
      end else begin
        exp_v = exp_q.pop_front();
        assert (obs === exp_v) else begin
          n_err++;
          $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, i, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rdy = 1'b0; nb = 5'd15; nw = 4'd1; gap = '0;
`ifdef I2S_DSP_WS_LONG_FS_EN
    long_fs = 1'b0;
`endif
    repeat (3) @(negedge sck);
    push_const(IDLEV, 2);
    run(2, "reset_state");

    // Basic back-to-back 2x16 frames
    rst = 1'b0; en = 1'b1; rdy = 1'b1;
    push_frame(15, 1, 0); push_frame(15, 1, 0); push_frame(15, 1, 0);
    run(96, "basic");

    // Reset mid-frame, then idle until ready returns
    push_range(15, 1, 0, 0, 4);
    run(5, "pre_reset");
    rst = 1'b1; rdy = 1'b0;
    push_const(IDLEV, 3);
    run(3, "reset_mid");
    rst = 1'b0;
    push_const(IDLEV, 4);
    run(4, "idle_no_ready");

    // Gap: 8-bit single-word frames with 5 idle cycles
    nb = 5'd7; nw = 4'd0; gap = 8'd5; rdy = 1'b1;
    push_frame(7, 0, 0); push_const(GAPV, 5);
    push_frame(7, 0, 0); push_const(GAPV, 5);
    push_frame(7, 0, 0);
    run(34, "gap");

    // New config picked up after the gap; ready dropped at bit 3
    nb = 5'd15; nw = 4'd1; gap = '0;
    push_const(GAPV, 5);
    push_range(15, 1, 0, 0, 3);
    run(9, "gap_to_frame");
    rdy = 1'b0;
    push_range(15, 1, 0, 4, 31);
    push_const(IDLEV, 4);
    run(32, "ready_drop");

    // Enable drop at word 1 bit 4, then re-enable
    rdy = 1'b1;
    push_range(15, 1, 0, 0, 20);
    run(21, "pre_en_drop");
    en = 1'b0;
    push_const(IDLEV, 3);
    run(3, "en_drop");
    en = 1'b1;
    push_frame(15, 1, 0);
    run(32, "re_enable");

    // Config change mid-frame takes effect at the next frame
    push_range(15, 1, 0, 0, 9);
    run(10, "cfg_pre");
    nb = 5'd31;
`ifdef I2S_DSP_WS_LONG_FS_EN
    long_fs = 1'b1; lng_exp = 1'b1;
`endif
    push_range(15, 1, 0, 10, 31);
    push_frame(31, 1, lng_exp);
    run(86, "cfg_change");
    en = 1'b0;
`ifdef I2S_DSP_WS_LONG_FS_EN
    long_fs = 1'b0; lng_exp = 1'b0;
`endif
    push_const(IDLEV, 2);
    run(2, "cfg_stop");

    // Minimum frame: one 1-bit word per frame
    nb = 5'd0; nw = 4'd0; en = 1'b1;
    push_frame(0, 0, 0); push_frame(0, 0, 0); push_frame(0, 0, 0); push_frame(0, 0, 0);
    run(4, "min_frame");
    en = 1'b0;
    push_const(IDLEV, 1);
    run(1, "min_stop");

    // Maximum frame: 16 words of 32 bits
    nb = 5'd31; nw = 4'd15; en = 1'b1;
    push_frame(31, 15, 0);
    run(512, "max_frame");
    en = 1'b0;
    push_const(IDLEV, 2);
    run(2, "max_stop");

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
